mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store stage between the datapath and the word-wide data memory. Consumes the control unit's memory signals (memRead, memWrite, memDataSize, memBitExt) with the ALU-computed address and the rt store data. Performs byte/halfword lane steering, byte-enable generation, alignment checking and load sign/zero extension. Runs a request/acknowledge handshake with the memory and stalls the pipeline until the access completes.

## Interface
- TIMEOUT, 16: maximum cycles to wait for mAck before a bus error; 2..255.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- memRead  in  1  load request from control unit.
- memWrite  in  1  store request; has priority if both are high.
- memDataSize  in  2  0 = word, 1 = half, 2 = byte, 3 = invalid.
- memBitExt  in  1  load extension: 0 = sign, 1 = zero.
- addr  in  32  byte address from the ALU.
- wdata  in  32  store data; the low bits are used for half and byte.
- rdata  out  32  extended load result; held until the next load completes.
- stall  out  1  freeze PC and pipeline registers.
- accessFault  out  1  one-cycle pulse: misaligned address or size 3.
- busError  out  1  one-cycle pulse: mAck timeout.
- mAddr  out  32  word address, {addr[31:2], 2'b00}.
- mWdata  out  32  lane-replicated store data.
- mByteEn  out  4  active lanes; bit i is bits 8i+7:8i.
- mReq  out  1  memory request.
- mWe  out  1  1 = write.
- mAck  in  1  memory done; mRdata is valid in the same cycle.
- mRdata  in  32  memory read word.

## Operation
- Little-endian. Lane = addr[1:0] for byte, addr[1] for half.
- Alignment:
  - Word requires addr[1:0] = 0.
  - Half requires addr[0] = 0.
  - Byte is always aligned.
  - Size 3 is always a fault.
- Byte enables:
  - Word: 4'b1111.
  - Half: 4'b0011 or 4'b1100.
  - Byte: 4'b0001 shifted left by addr[1:0].
- mWdata: byte is {4{wdata[7:0]}}; half is {2{wdata[15:0]}}; word is wdata.
- Load extraction: select the lane from mRdata, then extend to 32 bits (sign if memBitExt = 0, zero if 1). A word ignores memBitExt.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE, request (memRead | memWrite) and legal: latch addr, size, ext, we, byte enables and mWdata into internal registers; go to ACCESS. stall = 1 combinationally in this cycle.
  - IDLE, request and illegal: pulse accessFault; stay in IDLE; stall = 0; no memory transaction; rdata unchanged.
  - ACCESS: mReq = 1; mWe, mAddr, mByteEn and mWdata come from the latched registers and are stable; stall = 1; the timeout counter increments.
    - mAck = 1: a load captures the extended result into rdata; go to DONE.
    - Counter reaches TIMEOUT - 1 without mAck: pulse busError; rdata unchanged; go to DONE.
  - DONE: mReq = 0; stall = 0. The pipeline advances on this edge. Go to IDLE unconditionally. Requests are not sampled in DONE, so the completed instruction cannot retrigger.
- Timeout counter: 8 bits, cleared on entry to ACCESS.
- mAck outside ACCESS is ignored.

## Timing
- Reset (rst = 0), asynchronous and immediate:
  - state = IDLE; counter = 0.
  - rdata = 0; mAddr, mWdata, mByteEn = 0.
  - mReq = 0, mWe = 0, stall = 0, accessFault = 0, busError = 0.
- Reset during ACCESS aborts the transaction. mReq drops asynchronously; the memory must tolerate the abandoned request.
- Latency with mAck on the first ACCESS cycle: the request cycle, ACCESS and DONE take 3 cycles; stall is high for 2.
  - General case: stall high for 1 + N cycles, where N is the number of ACCESS cycles (N ≤ TIMEOUT).
- rdata is valid from the DONE cycle onward; it is registered, not combinational from mRdata.
- accessFault is combinational in the IDLE request cycle. busError is registered and high during the DONE cycle.
- Back-to-back accesses: the next request is sampled in the IDLE cycle after DONE. Minimum spacing is 3 cycles.
- Inputs may change while stall = 1; the block uses only its latched copies.

## Test plan
- Byte load, sign-extended: addr = 0x1003, mRdata = 0x80FF1122, size 2, ext 0, mAck on the first ACCESS cycle. Required: mByteEn = 4'b1000, rdata = 0xFFFFFF80 in DONE, stall high for exactly 2 cycles.
- Half load, zero-extended: addr = 0x2002, mRdata = 0xBEEF1234, size 1, ext 1. Required: rdata = 0x0000BEEF. Repeat with ext 0: required rdata = 0xFFFFBEEF.
- Byte store: addr = 0x11, wdata = 0xDEADBEAB, memWrite = 1, size 2. Required: mAddr = 0x10, mByteEn = 4'b0010, mWdata = 0xABABABAB, mWe = 1 held until mAck; rdata unchanged.
- Misaligned access: word load at addr = 0x6, then half store at addr = 0x5, then size 3. Required: accessFault pulses 1 cycle each, mReq never asserts, stall stays 0.
- Timeout: TIMEOUT = 4, mAck held at 0. Required: ACCESS lasts 4 cycles, busError pulses in DONE, rdata unchanged. Then hold memRead and memWrite both high: required mWe = 1 (the write wins).
- Reset mid-access: assert rst = 0 in the 2nd ACCESS cycle. Required: mReq, stall and rdata go to 0 immediately. After release, a word load with mAck delayed 3 cycles returns mRdata exactly.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Word-wide data memory bus between the load/store stage and memory.
// The master issues requests; the slave answers with mAck and mRdata.
interface mem_access_unit_if;
  logic [31:0] mAddr;
  logic [31:0] mWdata;
  logic [3:0]  mByteEn;
  logic        mReq;
  logic        mWe;
  logic        mAck;
  logic [31:0] mRdata;

  modport master (
    output mAddr, mWdata, mByteEn, mReq, mWe,
    input  mAck, mRdata
  );

  modport slave (
    input  mAddr, mWdata, mByteEn, mReq, mWe,
    output mAck, mRdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store stage: lane steering, byte enables, alignment checking, load extension,
// and a req/ack memory handshake that stalls the pipeline until the access completes.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [1:0]        memDataSize,
  input  logic              memBitExt,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              accessFault,
  output logic              busError,
  mem_access_unit_if.master mem
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [29:0] waddr_q, waddr_d;
  logic [1:0]  lane_q, lane_d;
  logic [1:0]  size_q, size_d;
  logic        ext_q, ext_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] rdata_q, rdata_d;
  logic        bus_err_q, bus_err_d;

  logic        req;
  logic        legal;
  logic [3:0]  req_be;
  logic [31:0] req_wdat;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;

  assign req = memRead | memWrite;

  // Decode the incoming request: legality, lane enables and replicated store data.
  always_comb begin
    legal    = 1'b0;
    req_be   = 4'b0000;
    req_wdat = 32'h0;
    case (memDataSize)
      2'd0: begin
        legal    = (addr[1:0] == 2'b00);
        req_be   = 4'b1111;
        req_wdat = wdata;
      end
      2'd1: begin
        legal    = ~addr[0];
        req_be   = addr[1] ? 4'b1100 : 4'b0011;
        req_wdat = {2{wdata[15:0]}};
      end
      2'd2: begin
        legal    = 1'b1;
        req_be   = 4'b0001 << addr[1:0];
        req_wdat = {4{wdata[7:0]}};
      end
      default: begin
        legal    = 1'b0;
      end
    endcase
  end

  // Load path works only from the latched size/lane/ext, never from live inputs.
  always_comb begin
    ld_byte = 8'h0;
    ld_half = lane_q[1] ? mem.mRdata[31:16] : mem.mRdata[15:0];
    case (lane_q)
      2'd0:    ld_byte = mem.mRdata[7:0];
      2'd1:    ld_byte = mem.mRdata[15:8];
      2'd2:    ld_byte = mem.mRdata[23:16];
      default: ld_byte = mem.mRdata[31:24];
    endcase
    case (size_q)
      2'd1:    ld_val = {{16{~ext_q & ld_half[15]}}, ld_half};
      2'd2:    ld_val = {{24{~ext_q & ld_byte[7]}}, ld_byte};
      default: ld_val = mem.mRdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    waddr_d     = waddr_q;
    lane_d      = lane_q;
    size_d      = size_q;
    ext_d       = ext_q;
    we_d        = we_q;
    be_d        = be_q;
    wdat_d      = wdat_q;
    rdata_d     = rdata_q;
    bus_err_d   = 1'b0;
    stall       = 1'b0;
    accessFault = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (legal) begin
            waddr_d = addr[31:2];
            lane_d  = addr[1:0];
            size_d  = memDataSize;
            ext_d   = memBitExt;
            we_d    = memWrite;
            be_d    = req_be;
            wdat_d  = req_wdat;
            cnt_d   = 8'd0;
            stall   = 1'b1;
            state_d = ACCESS;
          end else begin
            accessFault = 1'b1;
          end
        end
      end
      ACCESS: begin
        stall = 1'b1;
        cnt_d = cnt_q + 8'd1;
        // An ack in the last allowed cycle still wins over the timeout.
        if (mem.mAck) begin
          if (!we_q) rdata_d = ld_val;
          state_d = DONE;
        end else if (cnt_q == LAST_CNT) begin
          bus_err_d = 1'b1;
          state_d   = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      waddr_q   <= 30'h0;
      lane_q    <= 2'd0;
      size_q    <= 2'd0;
      ext_q     <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= 4'b0000;
      wdat_q    <= 32'h0;
      rdata_q   <= 32'h0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      waddr_q   <= waddr_d;
      lane_q    <= lane_d;
      size_q    <= size_d;
      ext_q     <= ext_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdat_q    <= wdat_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign rdata       = rdata_q;
  assign busError    = bus_err_q;
  assign mem.mReq    = (state_q == ACCESS);
  assign mem.mWe     = (state_q == ACCESS) & we_q;
  assign mem.mAddr   = {waddr_q, 2'b00};
  assign mem.mByteEn = be_q;
  assign mem.mWdata  = wdat_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized accesses
// compared against an arithmetic reference model of the load/store rules.
module tb_mem_access_unit;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        memRead = 1'b0;
  logic        memWrite = 1'b0;
  logic [1:0]  memDataSize = 2'd0;
  logic        memBitExt = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        stall;
  logic        accessFault;
  logic        busError;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_rdata = 32'h0;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .memDataSize (memDataSize),
    .memBitExt   (memBitExt),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .stall       (stall),
    .accessFault (accessFault),
    .busError    (busError),
    .mem         (bus)
  );

  always #5 clk = ~clk;

  function automatic logic legal_m(input logic [1:0] sz, input logic [31:0] a);
    case (sz)
      2'd0:    return (a % 4) == 0;
      2'd1:    return (a % 2) == 0;
      2'd2:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] be_m(input logic [1:0] sz, input logic [31:0] a);
    case (sz)
      2'd0:    return 4'hF;
      2'd1:    return ((a % 4) >= 2) ? 4'hC : 4'h3;
      default: return 4'(32'd1 << (a % 4));
    endcase
  endfunction

  function automatic logic [31:0] wd_m(input logic [1:0] sz, input logic [31:0] w);
    case (sz)
      2'd0:    return w;
      2'd1:    return (w % 32'h10000) * 32'h00010001;
      default: return (w % 32'h100) * 32'h01010101;
    endcase
  endfunction

  function automatic logic [31:0] ld_m(input logic [1:0] sz, input logic [31:0] a,
                                       input logic ex, input logic [31:0] word);
    int unsigned bits;
    logic [31:0] range;
    logic [31:0] v;
    if (sz == 2'd0) return word;
    bits  = (sz == 2'd1) ? 16 : 8;
    range = 32'd1 << bits;
    v     = (word >> (8 * (a % 4))) % range;
    if (!ex && v >= range / 2) v = v - range;
    return v;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One complete access from the request cycle through DONE. delay = number of
  // ACCESS cycles without mAck before it is raised; delay >= TO forces a timeout.
  task automatic apply_stimulus(input logic rd, input logic wr, input logic [1:0] sz,
                                input logic ex, input logic [31:0] a, input logic [31:0] w,
                                input logic [31:0] word, input int delay);
    logic legal;
    logic ack;
    int   n;
    int   stall_cnt;
    int   exp_n;
    legal = legal_m(sz, a);
    @(posedge clk); #1;
    memRead = rd; memWrite = wr; memDataSize = sz; memBitExt = ex;
    addr = a; wdata = w; bus.mAck = 1'b0;
    @(negedge clk);
    stall_cnt = int'(stall);
    check_output("req_stall", 32'(stall), 32'(legal));
    check_output("req_fault", 32'(accessFault), 32'(!legal));
    check_output("req_mreq", 32'(bus.mReq), 32'd0);
    if (!legal) begin
      @(posedge clk); #1;
      memRead = 1'b0; memWrite = 1'b0;
      @(negedge clk);
      check_output("fault_pulse", 32'(accessFault), 32'd0);
      check_output("fault_mreq", 32'(bus.mReq), 32'd0);
      check_output("fault_stall", 32'(stall), 32'd0);
      check_output("fault_rdata", rdata, exp_rdata);
      return;
    end
    n   = 0;
    ack = 1'b0;
    for (int k = 0; k < int'(TO) && !ack; k++) begin
      @(posedge clk); #1;
      memRead = 1'b0; memWrite = 1'b0;
      addr = $urandom; wdata = $urandom;
      memDataSize = 2'($urandom); memBitExt = 1'($urandom);
      ack = (k == delay);
      bus.mAck = ack;
      bus.mRdata = ack ? word : $urandom;
      @(negedge clk);
      n++;
      stall_cnt += int'(stall);
      check_output("acc_mreq", 32'(bus.mReq), 32'd1);
      check_output("acc_mwe", 32'(bus.mWe), 32'(wr));
      check_output("acc_maddr", bus.mAddr, a - (a % 4));
      check_output("acc_mbyteen", 32'(bus.mByteEn), 32'(be_m(sz, a)));
      if (wr) check_output("acc_mwdata", bus.mWdata, wd_m(sz, w));
    end
    @(posedge clk); #1;
    bus.mAck = 1'b0;
    @(negedge clk);
    if (!wr && ack) exp_rdata = ld_m(sz, a, ex, word);
    exp_n = ack ? delay + 1 : int'(TO);
    check_output("access_cycles", 32'(n), 32'(exp_n));
    check_output("stall_cycles", 32'(stall_cnt), 32'(1 + exp_n));
    check_output("done_stall", 32'(stall), 32'd0);
    check_output("done_mreq", 32'(bus.mReq), 32'd0);
    check_output("done_buserr", 32'(busError), 32'(!ack));
    check_output("done_rdata", rdata, exp_rdata);
  endtask

  initial begin
    logic        rd;
    logic        wr;
    logic [31:0] a;
    bus.mAck   = 1'b0;
    bus.mRdata = 32'h0;

    #12;
    check_output("rst_rdata", rdata, 32'h0);
    check_output("rst_maddr", bus.mAddr, 32'h0);
    check_output("rst_mwdata", bus.mWdata, 32'h0);
    check_output("rst_mbyteen", 32'(bus.mByteEn), 32'h0);
    check_output("rst_mreq", 32'(bus.mReq), 32'd0);
    check_output("rst_mwe", 32'(bus.mWe), 32'd0);
    check_output("rst_stall", 32'(stall), 32'd0);
    check_output("rst_fault", 32'(accessFault), 32'd0);
    check_output("rst_buserr", 32'(busError), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    apply_stimulus(1'b1, 1'b0, 2'd2, 1'b0, 32'h1003, 32'h0, 32'h80FF1122, 0);
    check_output("byte_sext_val", rdata, 32'hFFFFFF80);
    apply_stimulus(1'b1, 1'b0, 2'd1, 1'b1, 32'h2002, 32'h0, 32'hBEEF1234, 1);
    check_output("half_zext_val", rdata, 32'h0000BEEF);
    apply_stimulus(1'b1, 1'b0, 2'd1, 1'b0, 32'h2002, 32'h0, 32'hBEEF1234, 0);
    check_output("half_sext_val", rdata, 32'hFFFFBEEF);
    apply_stimulus(1'b0, 1'b1, 2'd2, 1'b0, 32'h11, 32'hDEADBEAB, 32'h0, 2);
    check_output("store_keep_rdata", rdata, 32'hFFFFBEEF);

    apply_stimulus(1'b1, 1'b0, 2'd0, 1'b0, 32'h6, 32'h0, 32'h0, 0);
    apply_stimulus(1'b0, 1'b1, 2'd1, 1'b0, 32'h5, 32'h1234, 32'h0, 0);
    apply_stimulus(1'b1, 1'b0, 2'd3, 1'b0, 32'h8, 32'h0, 32'h0, 0);

    apply_stimulus(1'b1, 1'b0, 2'd0, 1'b0, 32'h40, 32'h0, 32'h12345678, 99);
    check_output("timeout_rdata", rdata, 32'hFFFFBEEF);
    apply_stimulus(1'b1, 1'b1, 2'd0, 1'b0, 32'h100, 32'hCAFEF00D, 32'h0, 0);

    apply_stimulus(1'b1, 1'b0, 2'd0, 1'b0, 32'h44, 32'h0, 32'hA5A55A5A, 0);
    @(posedge clk); #1;
    memRead = 1'b1; memWrite = 1'b0; memDataSize = 2'd0; addr = 32'h80; bus.mAck = 1'b0;
    @(posedge clk); #1;
    memRead = 1'b0;
    @(posedge clk); #1;
    check_output("pre_rst_mreq", 32'(bus.mReq), 32'd1);
    rst = 1'b0;
    #1;
    check_output("midrst_mreq", 32'(bus.mReq), 32'd0);
    check_output("midrst_stall", 32'(stall), 32'd0);
    check_output("midrst_rdata", rdata, 32'h0);
    exp_rdata = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(1'b1, 1'b0, 2'd0, 1'b0, 32'hC0, 32'h0, 32'h13579BDF, 3);
    check_output("post_rst_word", rdata, 32'h13579BDF);

    for (int i = 0; i < 40; i++) begin
      rd = 1'($urandom);
      wr = 1'($urandom);
      if (!rd && !wr) rd = 1'b1;
      a = $urandom;
      apply_stimulus(rd, wr, 2'($urandom), 1'($urandom), a, $urandom, $urandom,
                     int'($urandom_range(0, 5)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
